// File: rtl/cpu_run_controller_pkg.sv
// Shared types for the CPU run controller: FSM states and verdict flags.
// Pure declarations; no timing or flow-control behaviour of its own.
package cpu_run_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RST_HOLD = 2'd1,
        RUN      = 2'd2,
        DONE     = 2'd3
    } state_t;

    typedef struct packed {
        logic pass;
        logic fail;
        logic timeout;
    } verdict_t;

    localparam verdict_t VERDICT_NONE    = '{pass: 1'b0, fail: 1'b0, timeout: 1'b0};
    localparam verdict_t VERDICT_PASS    = '{pass: 1'b1, fail: 1'b0, timeout: 1'b0};
    localparam verdict_t VERDICT_FAIL    = '{pass: 1'b0, fail: 1'b1, timeout: 1'b0};
    localparam verdict_t VERDICT_TIMEOUT = '{pass: 1'b0, fail: 1'b1, timeout: 1'b1};

    function automatic verdict_t compare_verdict(input logic match);
        return match ? VERDICT_PASS : VERDICT_FAIL;
    endfunction

endpackage

// File: rtl/cpu_run_controller_if.sv
// Control/status bundle between bench or board control and the run controller.
// Wires only; all timing is owned by the controller (registered outputs, no backpressure).
interface cpu_run_if #(
    parameter int SIZE  = 8,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic             mode_step;
    logic             step;
    logic             halt;
    logic [SIZE-1:0]  result;
    logic [SIZE-1:0]  expected;
    logic             cpu_rstn;
    logic             cpu_en;
    logic             running;
    logic             done;
    logic             pass;
    logic             fail;
    logic             timeout;
    logic [CNT_W-1:0] cycle_count;

    modport master (
        output start, abort, mode_step, step, halt, result, expected,
        input  cpu_rstn, cpu_en, running, done, pass, fail, timeout, cycle_count
    );

    modport slave (
        input  start, abort, mode_step, step, halt, result, expected,
        output cpu_rstn, cpu_en, running, done, pass, fail, timeout, cycle_count
    );
endinterface

// File: rtl/cpu_run_controller_sat_counter.sv
// Clear/increment counter that sticks at all-ones; clear has priority over increment.
// Latency: value updates one cycle after clr/inc; no backpressure.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] q_nxt;

    always_comb begin
        q_nxt = q;
        if (clr) begin
            q_nxt = '0;
        end else if (inc && (q != {W{1'b1}})) begin
            q_nxt = q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else begin
            q <= q_nxt;
        end
    end
endmodule

// File: rtl/cpu_run_controller.sv
// Run controller: CPU reset sequencing, free-run/single-step enable, cycle count, halt/watchdog verdict.
// Latency: every output registered, one cycle after its cause; no backpressure, steps arriving while enabled are dropped.
module cpu_run_controller
    import cpu_run_pkg::*;
#(
    parameter int SIZE           = 8,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 10,
    parameter int CNT_W          = 16
) (
    input  logic    clk,
    input  logic    rstn,
    cpu_run_if.slave bus
);
    localparam int               HOLD_W    = $clog2(RST_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
    localparam bit               TO_EN     = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TO_V      = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_M1     = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    if (RST_CYCLES < 1) begin : g_bad_rst
        $error("cpu_run_controller: RST_CYCLES must be at least 1");
    end
    if (longint'(TIMEOUT_CYCLES) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_to
        $error("cpu_run_controller: TIMEOUT_CYCLES does not fit in CNT_W bits");
    end

    state_t            state_q, state_nxt;
    verdict_t          verdict_q, verdict_nxt;
    logic              mode_q, mode_nxt;
    logic              cpu_rstn_q, cpu_en_q, running_q, done_q;
    logic              en_nxt, clr_cnt, budget_hit;
    logic [HOLD_W-1:0] hold_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [SIZE-1:0]   res_w, exp_w;

    assign res_w = bus.result;
    assign exp_w = bus.expected;

    // Budget is hit when the count after this cycle would equal the watchdog limit,
    // so the CPU never sees more than TIMEOUT_CYCLES enabled cycles.
    assign budget_hit = TO_EN && (cpu_en_q ? (cnt_q == TO_M1) : (cnt_q == TO_V));

    always_comb begin
        state_nxt   = state_q;
        verdict_nxt = verdict_q;
        mode_nxt    = mode_q;
        clr_cnt     = 1'b0;
        if (bus.abort) begin
            state_nxt   = IDLE;
            verdict_nxt = VERDICT_NONE;
            clr_cnt     = 1'b1;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state_nxt   = RST_HOLD;
                        verdict_nxt = VERDICT_NONE;
                        mode_nxt    = bus.mode_step;
                        clr_cnt     = 1'b1;
                    end
                end
                RST_HOLD: begin
                    if (hold_q == HOLD_LAST) begin
                        state_nxt = RUN;
                    end
                end
                RUN: begin
                    if (bus.halt) begin
                        state_nxt   = DONE;
                        verdict_nxt = compare_verdict(res_w == exp_w);
                    end else if (TO_EN && (cnt_q == TO_V)) begin
                        state_nxt   = DONE;
                        verdict_nxt = VERDICT_TIMEOUT;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        en_nxt = 1'b0;
        if (state_nxt == RUN) begin
            if (state_q == RST_HOLD) begin
                en_nxt = !mode_q;
            end else begin
                en_nxt = mode_q ? (bus.step && !cpu_en_q) : 1'b1;
            end
            if (budget_hit) begin
                en_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            verdict_q  <= VERDICT_NONE;
            mode_q     <= 1'b0;
            cpu_rstn_q <= 1'b0;
            cpu_en_q   <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            verdict_q  <= verdict_nxt;
            mode_q     <= mode_nxt;
            cpu_rstn_q <= (state_nxt == RUN) || (state_nxt == DONE);
            cpu_en_q   <= en_nxt;
            running_q  <= (state_nxt == RUN);
            done_q     <= (state_nxt == DONE);
        end
    end

    sat_counter #(.W(HOLD_W)) u_hold (
        .clk  (clk),
        .rstn (rstn),
        .clr  (state_q != RST_HOLD),
        .inc  (1'b1),
        .q    (hold_q)
    );

    sat_counter #(.W(CNT_W)) u_cycles (
        .clk  (clk),
        .rstn (rstn),
        .clr  (clr_cnt),
        .inc  (cpu_en_q),
        .q    (cnt_q)
    );

    assign bus.cpu_rstn    = cpu_rstn_q;
    assign bus.cpu_en      = cpu_en_q;
    assign bus.running     = running_q;
    assign bus.done        = done_q;
    assign bus.pass        = verdict_q.pass;
    assign bus.fail        = verdict_q.fail;
    assign bus.timeout     = verdict_q.timeout;
    assign bus.cycle_count = cnt_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed and randomized runs of cpu_run_controller against a count-based reference of enabled cycles and verdicts.
module tb_cpu_run_controller;
    localparam int SIZE  = 8;
    localparam int RST   = 2;
    localparam int TO    = 10;
    localparam int CNT_W = 16;
    localparam int MAXK  = 40;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    cpu_run_if #(.SIZE(SIZE), .CNT_W(CNT_W)) bus ();

    cpu_run_controller #(
        .SIZE(SIZE), .RST_CYCLES(RST), .TIMEOUT_CYCLES(TO), .CNT_W(CNT_W)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // {cpu_rstn, cpu_en, running, done, pass, fail, timeout, cycle_count}
    function automatic logic [31:0] observe();
        return {9'd0, bus.cpu_rstn, bus.cpu_en, bus.running, bus.done,
                bus.pass, bus.fail, bus.timeout, bus.cycle_count};
    endfunction

    function automatic logic [31:0] expv(input bit r, input bit e, input bit ru, input bit d,
                                         input bit p, input bit f, input bit t, input int cnt);
        logic [15:0] c;
        c = cnt[15:0];
        return {9'd0, r, e, ru, d, p, f, t, c};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // One complete run from IDLE/DONE to DONE. halt_k / stepm are indexed by RUN cycle (0 = first RUN cycle).
    task automatic do_run(input string tag, input bit mode, input int halt_k, input logic [63:0] stepm,
                          input logic [7:0] res, input logic [7:0] gold, input bit noise);
        bit          en[MAXK];
        int          cnt_at[MAXK];
        int          e, cnt, fin, k;
        bit          req, ek, vp, vf, vt;
        logic [31:0] exp, done_v;

        // Reference: enabled cycles come from the budget (free) or one cycle after an accepted step.
        cnt = 0; req = 0; e = -1; fin = 0; vp = 0; vf = 0; vt = 0;
        for (int i = 0; i < MAXK && e < 0; i++) begin
            ek = mode ? req : (cnt < TO);
            en[i] = ek;
            cnt_at[i] = cnt;
            if (i == halt_k) begin
                e = i; vp = (res == gold); vf = !vp; fin = cnt + int'(ek);
            end else if (cnt == TO) begin
                e = i; vf = 1; vt = 1; fin = cnt;
            end
            req = mode && stepm[i] && !ek && (cnt + int'(ek) < TO);
            cnt += int'(ek);
        end
        if (e < 0) begin
            total++; bad++;
            $error("FAIL %s.model: run has no end within %0d cycles", tag, MAXK);
            e = MAXK - 1;
        end
        done_v = expv(1, 0, 0, 1, vp, vf, vt, fin);

        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode_step = mode; bus.result = res; bus.expected = gold;
        for (int j = 1; j <= RST + e + 2; j++) begin
            @(posedge clk); #1;
            k = j - RST - 1;
            if (j <= RST)   exp = expv(0, 0, 0, 0, 0, 0, 0, 0);
            else if (k <= e) exp = expv(1, en[k], 1, 0, 0, 0, 0, cnt_at[k]);
            else            exp = done_v;
            check($sformatf("%s.c%0d", tag, j), observe(), exp);
            bus.halt  = (k == halt_k) || (noise && j <= RST && $urandom_range(1) == 1);
            bus.step  = (k >= 0) ? stepm[k] : (noise && $urandom_range(1) == 1);
            bus.start = noise && k >= 0 && k <= e && $urandom_range(3) == 0;
            if (noise) bus.mode_step = 1'($urandom_range(1));
        end
        // Verdict and count hold in DONE; a late mismatching halt must not disturb them.
        bus.halt = 1'b1; bus.step = 1'b0; bus.start = 1'b0; bus.result = ~gold;
        @(posedge clk); #1;
        check($sformatf("%s.hold", tag), observe(), done_v);
        bus.halt = 1'b0;
    endtask

    initial begin
        bit          m;
        int          hk;
        logic [63:0] sm;
        logic [7:0]  rv, gv;

        bus.start = 0; bus.abort = 0; bus.mode_step = 0; bus.step = 0; bus.halt = 0;
        bus.result = '0; bus.expected = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset", observe(), expv(0, 0, 0, 0, 0, 0, 0, 0));
        rstn = 1'b1;
        @(posedge clk); #1;
        check("idle", observe(), expv(0, 0, 0, 0, 0, 0, 0, 0));

        // T1: free-run, halt during the 5th enabled cycle, match
        do_run("t1", 0, 4, 64'd0, 8'hA5, 8'hA5, 0);
        check("t1.count", 32'(bus.cycle_count), 32'd5);
        check("t1.pass", {31'd0, bus.pass}, 32'd1);
        // T2: mismatch
        do_run("t2", 0, 4, 64'd0, 8'hA5, 8'h5A, 0);
        check("t2.flags", {29'd0, bus.pass, bus.fail, bus.timeout}, 32'b010);
        // T3: no halt, watchdog expires
        do_run("t3", 0, 99, 64'd0, 8'h11, 8'h11, 0);
        check("t3.flags", {29'd0, bus.pass, bus.fail, bus.timeout}, 32'b011);
        check("t3.count", 32'(bus.cycle_count), 32'd10);
        // T4: halt exactly when the count reaches the limit
        do_run("t4", 0, 10, 64'd0, 8'h3C, 8'h3C, 0);
        check("t4.flags", {29'd0, bus.pass, bus.fail, bus.timeout}, 32'b100);
        // T5: step mode, steps at RUN cycles 1,2 (duplicate) and 5, halt at 8
        do_run("t5", 1, 8, 64'h26, 8'h77, 8'h77, 0);
        check("t5.count", 32'(bus.cycle_count), 32'd2);

        // T6: abort in RUN at count 4
        @(posedge clk); #1;
        bus.start = 1'b1; bus.mode_step = 1'b0;
        for (int j = 1; j <= RST + 5; j++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
        end
        check("t6.cnt4", observe(), expv(1, 1, 1, 0, 0, 0, 0, 4));
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("t6.abort", observe(), expv(0, 0, 0, 0, 0, 0, 0, 0));
        // asynchronous reset in the middle of RST_HOLD
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("t6.hold", observe(), expv(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        #2 rstn = 1'b0;
        #1 check("t6.arst", observe(), expv(0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        rstn = 1'b1;
        check("t6.idle", observe(), expv(0, 0, 0, 0, 0, 0, 0, 0));
        do_run("t6.rerun", 0, 4, 64'd0, 8'hA5, 8'hA5, 0);

        // Randomized runs with ignored start/halt/step noise and mode_step toggling after latch
        for (int r = 0; r < 12; r++) begin
            m  = 1'($urandom_range(1));
            hk = $urandom_range(0, 25);
            sm = {$urandom, $urandom};
            rv = 8'($urandom);
            gv = ($urandom_range(1) == 1) ? rv : 8'($urandom);
            do_run($sformatf("rnd%0d", r), m, hk, sm, rv, gv, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "bench timeout");
    end
endmodule
